w450_mem_resp: RTL and testbench
================================

Name: w450_mem_resp

Overview:
- Memory responder for the w450 8-bit multicycle processor: 2^n x n array behind the processor's two combinational read ports and one write port.
- Adds a power-up clear sequencer and a byte-serial program loader with valid/ready handshake.
- Holds the processor in reset (cpu_reset) until a program is loaded.
- Keeps write statistics and a write-protect violation flag for verification.

Parameters:
n, 8, data and address width; array depth is 2^n words
WCNT_W, 16, width of the processor write counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
mem_rd_addr1  input  n  instruction read address (processor PC)
mem_rd_data1  output  n  combinational read data for addr1
mem_rd_addr2  input  n  r0-indirect read address
mem_rd_data2  output  n  combinational read data for addr2
mem_wr_addr  input  n  processor write address
mem_wr_data  input  n  processor write data
mem_wr_en  input  1  processor write strobe, sampled at rising edge
load_start  input  1  begin program load at address 0
load_valid  input  1  load_data valid
load_data  input  n  program byte
load_last  input  1  qualifies final byte of a load
load_ready  output  1  loader can accept a byte this cycle
cpu_reset  output  1  drives the processor's reset input
protect_en  input  1  block processor writes into the loaded program region
load_count  output  n+1  bytes accepted in the last/current load
wr_count  output  WCNT_W  accepted processor writes, saturating
wr_violation  output  1  sticky: a processor write was blocked

Behaviour:
- Reads:
  - mem_rd_data1 = mem[mem_rd_addr1] and mem_rd_data2 = mem[mem_rd_addr2], purely combinational, in every state.
  - Reading an address in the same cycle it is being written returns the old data; new data is visible after the edge.
- State machine ST_CLEAR, ST_IDLE, ST_LOAD, ST_RUN (2-bit encoding):
  - reset (any state, mid-load included) -> ST_CLEAR.
    - Clear pointer = 0; load_count = 0; wr_count = 0; wr_violation = 0; cpu_reset = 1; load_ready = 0.
  - ST_CLEAR:
    - Writes 0 to mem[ptr] each cycle and ptr increments.
    - After writing address 2^n-1, goes to ST_IDLE. Exactly 2^n cycles.
    - load_start is ignored during ST_CLEAR.
  - ST_IDLE: cpu_reset = 1, load_ready = 0. load_start -> ST_LOAD, load pointer = 0, load_count = 0.
  - ST_LOAD:
    - load_ready = 1, cpu_reset = 1.
    - On load_valid & load_ready: mem[ptr] <= load_data, ptr++, load_count++.
    - If load_last is also set, go to ST_RUN on the same edge.
    - Load of 2^n bytes without load_last: the byte at 2^n-1 is treated as last and the FSM goes to ST_RUN.
    - load_start while in ST_LOAD restarts at address 0 and zeroes load_count.
  - ST_RUN:
    - cpu_reset = 0, load_ready = 0.
    - load_start -> ST_LOAD: cpu_reset rises the next cycle, pointer = 0. Memory is not cleared.
- Processor writes:
  - Accepted only in ST_RUN when mem_wr_en = 1 at the edge.
  - Writes in other states are dropped and not counted.
  - With protect_en = 1, a write with mem_wr_addr < load_count is blocked: memory unchanged, wr_violation set (sticky until reset), wr_count unchanged.
  - Accepted writes update mem[mem_wr_addr] <= mem_wr_data and increment wr_count, which saturates at all-ones.
- Write priority: clear > loader > processor. Loader and processor cannot coincide because processor writes are dropped outside ST_RUN.
- Output timing:
  - All outputs except the read data are registered or derived from the state register.
  - cpu_reset is a registered output equal to (state != ST_RUN).

Test Plan:
- Reset, run 256 cycles -> load_ready = 0 and cpu_reset = 1 throughout. Read addresses 0x00, 0x7F, 0xFF -> 0x00. State is ST_IDLE at cycle 256.
- load_start, then bytes 0xA1, 0x22, 0x33 with load_last on 0x33, load_valid dropped one cycle between bytes -> mem[0..2] = A1, 22, 33, load_count = 3. cpu_reset falls the cycle after 0x33 is accepted.
- In ST_RUN: write 0x5C to 0x10, read addr2 = 0x10 in the write cycle -> 0x00. Next cycle -> 0x5C. wr_count = 1.
- protect_en = 1 after a 3-byte load, processor writes 0xFF to 0x01 -> mem[1] stays 0x22, wr_violation = 1, wr_count unchanged. Write to 0x03 succeeds.
- Assert reset after 2 bytes of a load -> returns to ST_CLEAR, memory cleared to 0, load_count = 0, cpu_reset = 1.
- mem_wr_en pulses in ST_IDLE and ST_LOAD -> memory and wr_count unaffected.

Source files
------------

// File: rtl/w450_mem_resp_if.sv
// rtl/w450_mem_resp_if.sv - processor read/write ports and byte-serial loader bundle for w450_mem_resp
interface w450_mem_resp_if #(
    parameter int n = 8
);
    logic [n-1:0] mem_rd_addr1;
    logic [n-1:0] mem_rd_data1;
    logic [n-1:0] mem_rd_addr2;
    logic [n-1:0] mem_rd_data2;
    logic [n-1:0] mem_wr_addr;
    logic [n-1:0] mem_wr_data;
    logic         mem_wr_en;
    logic         load_start;
    logic         load_valid;
    logic [n-1:0] load_data;
    logic         load_last;
    logic         load_ready;

    modport master (
        output mem_rd_addr1, mem_rd_addr2, mem_wr_addr, mem_wr_data, mem_wr_en,
        output load_start, load_valid, load_data, load_last,
        input  mem_rd_data1, mem_rd_data2, load_ready
    );

    modport slave (
        input  mem_rd_addr1, mem_rd_addr2, mem_wr_addr, mem_wr_data, mem_wr_en,
        input  load_start, load_valid, load_data, load_last,
        output mem_rd_data1, mem_rd_data2, load_ready
    );
endinterface

// File: rtl/w450_mem_resp.sv
// rtl/w450_mem_resp.sv - w450 memory with power-up clear, program loader, cpu reset hold and write statistics
module w450_mem_resp #(
    parameter int n      = 8,
    parameter int WCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    w450_mem_resp_if.slave    bus,
    input  logic              protect_en,
    output logic              cpu_reset,
    output logic [n:0]        load_count,
    output logic [WCNT_W-1:0] wr_count,
    output logic              wr_violation
);
    localparam int DEPTH = 1 << n;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [n-1:0]      ptr_q, ptr_d;
    logic [n:0]        load_count_q, load_count_d;
    logic [WCNT_W-1:0] wr_count_q, wr_count_d;
    logic              wr_violation_q, wr_violation_d;
    logic              cpu_reset_q;
    logic [n-1:0]      mem_q [DEPTH];

    logic              mem_we;
    logic [n-1:0]      mem_waddr;
    logic [n-1:0]      mem_wdata;
    logic              ptr_last;
    logic              byte_take;
    logic              cpu_wr;
    logic              cpu_blocked;

    assign ptr_last    = &ptr_q;
    // A restart request wins over a byte presented in the same cycle.
    assign byte_take   = (state_q == ST_LOAD) && bus.load_valid && !bus.load_start;
    assign cpu_wr      = (state_q == ST_RUN) && bus.mem_wr_en;
    assign cpu_blocked = protect_en && ({1'b0, bus.mem_wr_addr} < load_count_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_CLEAR;
            ptr_q          <= '0;
            load_count_q   <= '0;
            wr_count_q     <= '0;
            wr_violation_q <= 1'b0;
            cpu_reset_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            load_count_q   <= load_count_d;
            wr_count_q     <= wr_count_d;
            wr_violation_q <= wr_violation_d;
            cpu_reset_q    <= (state_d != ST_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (ptr_last) state_d = ST_IDLE;
            ST_IDLE:  if (bus.load_start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (bus.load_start)                              state_d = ST_LOAD;
                else if (byte_take && (bus.load_last || ptr_last)) state_d = ST_RUN;
            end
            ST_RUN:   if (bus.load_start) state_d = ST_LOAD;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Write port priority: clear, then loader, then processor (the last two never overlap).
    always_comb begin
        ptr_d          = ptr_q;
        load_count_d   = load_count_q;
        wr_count_d     = wr_count_q;
        wr_violation_d = wr_violation_q;
        mem_we         = 1'b0;
        mem_waddr      = ptr_q;
        mem_wdata      = '0;
        if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + n'(1);
        end else if (bus.load_start) begin
            ptr_d        = '0;
            load_count_d = '0;
        end else if (byte_take) begin
            mem_we       = 1'b1;
            mem_wdata    = bus.load_data;
            ptr_d        = ptr_q + n'(1);
            load_count_d = load_count_q + (n+1)'(1);
        end
        if (cpu_wr) begin
            if (cpu_blocked) begin
                wr_violation_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = bus.mem_wr_addr;
                mem_wdata = bus.mem_wr_data;
                if (!(&wr_count_q)) wr_count_d = wr_count_q + WCNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.load_ready   = (state_q == ST_LOAD);
        bus.mem_rd_data1 = mem_q[bus.mem_rd_addr1];
        bus.mem_rd_data2 = mem_q[bus.mem_rd_addr2];
        cpu_reset        = cpu_reset_q;
        load_count       = load_count_q;
        wr_count         = wr_count_q;
        wr_violation     = wr_violation_q;
    end
endmodule

// File: tb/tb_w450_mem_resp.sv
// tb/tb_w450_mem_resp.sv - bench for w450_mem_resp: clear, load, protect, reset-abort and random traffic
module tb_w450_mem_resp;
    logic        clk;
    logic        reset;
    logic        protect_en;
    logic        cpu_reset;
    logic [8:0]  load_count;
    logic [15:0] wr_count;
    logic        wr_violation;

    w450_mem_resp_if #(.n(8)) bus ();

    w450_mem_resp #(.n(8), .WCNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .protect_en   (protect_en),
        .cpu_reset    (cpu_reset),
        .load_count   (load_count),
        .wr_count     (wr_count),
        .wr_violation (wr_violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [7:0]  wd;
        logic        prot;
        logic [7:0]  ra;
        logic [7:0]  exp_rd;
        logic [15:0] exp_cnt;
        logic        exp_viol;
    } vec_t;

    vec_t       vt [8];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_mem [256];
    int         m_len  = 0;
    int         m_cnt  = 0;
    logic       m_viol = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mwrite(input logic we, input logic [7:0] wa, input logic [7:0] wd, input logic prot);
        if (we) begin
            if (prot && (int'(wa) < m_len)) m_viol = 1'b1;
            else begin
                model_mem[wa] = wd;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    task automatic rd_chk(input logic [7:0] a);
        bus.mem_rd_addr1 = a;
        bus.mem_rd_addr2 = ~a;
        #1;
        chk("rd1", bus.mem_rd_data1, model_mem[a]);
        chk("rd2", bus.mem_rd_data2, model_mem[~a]);
    endtask

    task automatic feed(input logic [7:0] d, input logic last, input logic gap);
        if (gap) begin
            bus.load_valid = 1'b0;
            cyc();
        end
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        #1;
        chk("load_ready_byte", bus.load_ready, 1'b1);
        chk("cpu_reset_load", cpu_reset, 1'b1);
        cyc();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic do_load(input int len, input logic use_last);
        logic [7:0] d;
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        chk("cpu_reset_after_start", cpu_reset, 1'b1);
        chk("load_ready_after_start", bus.load_ready, 1'b1);
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            feed(d, use_last && (i == len - 1), 1'($urandom_range(0, 1)));
            model_mem[i] = d;
        end
        m_len = len;
        chk("cpu_reset_run", cpu_reset, 1'b0);
        chk("load_ready_run", bus.load_ready, 1'b0);
        chk("load_count", load_count, 32'(len));
    endtask

    task automatic traffic(input int ncyc);
        logic [7:0] a1, a2, wa, wd;
        logic       we, prot;
        for (int i = 0; i < ncyc; i++) begin
            a1   = 8'($urandom);
            a2   = 8'($urandom);
            wa   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, m_len)) : 8'($urandom);
            wd   = 8'($urandom);
            we   = 1'($urandom_range(0, 1));
            prot = 1'($urandom_range(0, 1));
            bus.mem_rd_addr1 = a1;
            bus.mem_rd_addr2 = a2;
            bus.mem_wr_addr  = wa;
            bus.mem_wr_data  = wd;
            bus.mem_wr_en    = we;
            protect_en       = prot;
            #1;
            chk("rnd_rd1", bus.mem_rd_data1, model_mem[a1]);
            chk("rnd_rd2", bus.mem_rd_data2, model_mem[a2]);
            cyc();
            mwrite(we, wa, wd, prot);
            bus.mem_wr_en = 1'b0;
            chk("rnd_wr_count", wr_count, 32'(m_cnt));
            chk("rnd_wr_violation", wr_violation, m_viol);
        end
    endtask

    task automatic clear_phase(input logic poke_start);
        for (int i = 0; i < 256; i++) begin
            bus.load_start = poke_start && (i == 100 || i == 255);
            #1;
            chk("clear_load_ready", bus.load_ready, 1'b0);
            chk("clear_cpu_reset", cpu_reset, 1'b1);
            cyc();
        end
        bus.load_start = 1'b0;
        chk("idle_load_ready", bus.load_ready, 1'b0);
        for (int a = 0; a < 256; a++) model_mem[a] = 8'h00;
    endtask

    initial begin
        vt[0] = '{1'b1, 8'h10, 8'h5C, 1'b0, 8'h10, 8'h00, 16'd1, 1'b0};
        vt[1] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h10, 8'h5C, 16'd1, 1'b0};
        vt[2] = '{1'b1, 8'h01, 8'hFF, 1'b1, 8'h01, 8'h22, 16'd1, 1'b1};
        vt[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h22, 16'd1, 1'b1};
        vt[4] = '{1'b1, 8'h03, 8'h44, 1'b1, 8'h03, 8'h00, 16'd2, 1'b1};
        vt[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 8'h44, 16'd2, 1'b1};
        vt[6] = '{1'b1, 8'h02, 8'h99, 1'b0, 8'h02, 8'h33, 16'd3, 1'b1};
        vt[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h02, 8'h99, 16'd3, 1'b1};

        reset = 1'b1;
        protect_en = 1'b0;
        bus.mem_rd_addr1 = '0; bus.mem_rd_addr2 = '0;
        bus.mem_wr_addr = '0;  bus.mem_wr_data = '0; bus.mem_wr_en = 1'b0;
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        cyc();
        cyc();
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_load_ready", bus.load_ready, 1'b0);
        chk("rst_load_count", load_count, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_wr_violation", wr_violation, 1'b0);
        reset = 1'b0;

        clear_phase(1'b1);
        rd_chk(8'h00);
        rd_chk(8'h7F);
        rd_chk(8'hFF);

        // processor write strobe in idle must be dropped
        bus.mem_wr_addr = 8'h40; bus.mem_wr_data = 8'h77; bus.mem_wr_en = 1'b1;
        cyc();
        bus.mem_wr_en = 1'b0;

        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        chk("load_ready_start", bus.load_ready, 1'b1);
        bus.mem_wr_addr = 8'h41; bus.mem_wr_data = 8'h66; bus.mem_wr_en = 1'b1;
        feed(8'hA1, 1'b0, 1'b1);
        bus.mem_wr_en = 1'b0;
        feed(8'h22, 1'b0, 1'b1);
        feed(8'h33, 1'b1, 1'b1);
        model_mem[0] = 8'hA1; model_mem[1] = 8'h22; model_mem[2] = 8'h33;
        m_len = 3;
        chk("first_cpu_reset", cpu_reset, 1'b0);
        chk("first_load_count", load_count, 3);
        chk("first_wr_count", wr_count, 0);
        for (int a = 0; a < 3; a++) rd_chk(8'(a));
        rd_chk(8'h40);
        rd_chk(8'h41);

        for (int i = 0; i < 8; i++) begin
            bus.mem_wr_en    = vt[i].we;
            bus.mem_wr_addr  = vt[i].wa;
            bus.mem_wr_data  = vt[i].wd;
            protect_en       = vt[i].prot;
            bus.mem_rd_addr2 = vt[i].ra;
            #1;
            chk($sformatf("vec%0d_rd", i), bus.mem_rd_data2, vt[i].exp_rd);
            cyc();
            mwrite(vt[i].we, vt[i].wa, vt[i].wd, vt[i].prot);
            chk($sformatf("vec%0d_cnt", i), wr_count, vt[i].exp_cnt);
            chk($sformatf("vec%0d_viol", i), wr_violation, vt[i].exp_viol);
        end
        bus.mem_wr_en = 1'b0;
        protect_en = 1'b0;

        // restart mid-load: only the second session counts, first session bytes stay in memory
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        feed(8'h11, 1'b0, 1'b0);
        feed(8'h12, 1'b0, 1'b1);
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        chk("restart_load_count", load_count, 0);
        feed(8'h13, 1'b1, 1'b0);
        model_mem[0] = 8'h13; model_mem[1] = 8'h12;
        m_len = 1;
        chk("restart_count_final", load_count, 1);
        chk("restart_cpu_reset", cpu_reset, 1'b0);
        for (int a = 0; a < 3; a++) rd_chk(8'(a));

        for (int r = 0; r < 3; r++) begin
            do_load($urandom_range(1, 24), 1'b1);
            traffic(120);
        end
        do_load(256, 1'b0);
        traffic(60);

        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        feed(8'hDE, 1'b0, 1'b0);
        feed(8'hAD, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort_cpu_reset", cpu_reset, 1'b1);
        chk("abort_load_ready", bus.load_ready, 1'b0);
        chk("abort_load_count", load_count, 0);
        chk("abort_wr_count", wr_count, 0);
        chk("abort_wr_violation", wr_violation, 1'b0);
        m_cnt = 0; m_viol = 1'b0; m_len = 0;
        clear_phase(1'b0);
        for (int a = 0; a < 256; a++) begin
            bus.mem_rd_addr1 = 8'(a);
            #1;
            chk("abort_cleared", bus.mem_rd_data1, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
